// File: rtl/lif_step_scheduler.sv
// Time-multiplexed leaky-integrate-and-fire scheduler: one shared update datapath scans
// NUM_NEURONS states per timestep. Optional refractory counters: define LIF_REFRACTORY_EN.
module lif_step_scheduler #(
  parameter int NUM_NEURONS  = 4,
  parameter int STATE_W      = 8,
  parameter int LEAK_SHIFT   = 2,
  parameter int SYN_WEIGHT   = 8,
  parameter int REFRAC_STEPS = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           step_start,
  input  logic [3:0]                     ext_input,
  input  logic [STATE_W-1:0]             threshold,
  input  logic [$clog2(NUM_NEURONS)-1:0] mon_sel,
  output logic                           busy,
  output logic                           step_done,
  output logic [NUM_NEURONS-1:0]         spike_vec,
  output logic [STATE_W-1:0]             state_mon
);

  localparam int IDX_W = $clog2(NUM_NEURONS);
  localparam int SUM_W = STATE_W + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic [IDX_W:0]   N_EXT    = (IDX_W + 1)'(NUM_NEURONS);
  localparam logic [SUM_W-1:0] SAT_MAX  = {2'b00, {STATE_W{1'b1}}};
  localparam logic [SUM_W-1:0] SYN_W    = SUM_W'(SYN_WEIGHT);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} fsm_t;

  fsm_t                   r_fsm;
  logic [IDX_W-1:0]       r_idx;
  logic [3:0]             r_ext;
  logic [STATE_W-1:0]     r_thr;
  logic [STATE_W-1:0]     r_state [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] r_shadow;
  logic [NUM_NEURONS-1:0] r_spike_vec;
  logic                   r_busy;
  logic                   r_step_done;
  logic [STATE_W-1:0]     r_state_mon;

`ifdef LIF_REFRACTORY_EN
  localparam int REF_W = (REFRAC_STEPS < 1) ? 1 : $clog2(REFRAC_STEPS + 1);
  localparam logic [REF_W-1:0] REF_LOAD = REF_W'(REFRAC_STEPS);
  logic [REF_W-1:0] r_refrac [NUM_NEURONS];
`else
  // REFRAC_STEPS has no counters to size in this build.
  logic w_unused_cfg;
  assign w_unused_cfg = (REFRAC_STEPS != 0);
`endif

  logic [SUM_W-1:0]   w_cur;
  logic [SUM_W-1:0]   w_leaked;
  logic [SUM_W-1:0]   w_syn;
  logic [SUM_W-1:0]   w_sum_raw;
  logic [SUM_W-1:0]   w_sum;
  logic               w_fire;
  logic [STATE_W-1:0] w_mon;

  // Synaptic term reads the committed spike_vec, never this timestep's shadow spikes.
  assign w_cur     = {2'b00, r_state[r_idx]};
  assign w_leaked  = w_cur - (w_cur >> LEAK_SHIFT);
  assign w_syn     = ((r_idx != '0) && r_spike_vec[r_idx - 1'b1]) ? SYN_W : '0;
  assign w_sum_raw = w_leaked + {{(SUM_W-4){1'b0}}, r_ext} + w_syn;
  assign w_sum     = (w_sum_raw > SAT_MAX) ? SAT_MAX : w_sum_raw;
  assign w_fire    = (w_sum >= {2'b00, r_thr});

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_mon = '0;
    if ({1'b0, mon_sel} < N_EXT) w_mon = r_state[mon_sel];
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm       <= S_IDLE;
      r_idx       <= '0;
      r_ext       <= '0;
      r_thr       <= '0;
      r_shadow    <= '0;
      r_spike_vec <= '0;
      r_busy      <= 1'b0;
      r_step_done <= 1'b0;
      r_state_mon <= '0;
      // NOTE: the state file is reset too, since a reset must discard any partial timestep.
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_state[i] <= '0;
`ifdef LIF_REFRACTORY_EN
        r_refrac[i] <= '0;
`endif
      end
    end else begin
      r_step_done <= 1'b0;
      r_state_mon <= w_mon;
      case (r_fsm)
        S_IDLE: begin
          if (step_start) begin
            r_ext  <= ext_input;
            r_thr  <= threshold;
            r_idx  <= '0;
            r_busy <= 1'b1;
            r_fsm  <= S_SCAN;
          end
        end
        S_SCAN: begin
`ifdef LIF_REFRACTORY_EN
          if (r_refrac[r_idx] != '0) begin
            r_state[r_idx]  <= '0;
            r_shadow[r_idx] <= 1'b0;
            r_refrac[r_idx] <= r_refrac[r_idx] - 1'b1;
          end else if (w_fire) begin
            r_state[r_idx]  <= '0;
            r_shadow[r_idx] <= 1'b1;
            r_refrac[r_idx] <= REF_LOAD;
          end else begin
            r_state[r_idx]  <= w_sum[STATE_W-1:0];
            r_shadow[r_idx] <= 1'b0;
          end
`else
          if (w_fire) begin
            r_state[r_idx]  <= '0;
            r_shadow[r_idx] <= 1'b1;
          end else begin
            r_state[r_idx]  <= w_sum[STATE_W-1:0];
            r_shadow[r_idx] <= 1'b0;
          end
`endif
          if (r_idx == LAST_IDX) r_fsm <= S_DONE;
          else                   r_idx <= r_idx + 1'b1;
        end
        S_DONE: begin
          r_spike_vec <= r_shadow;
          r_step_done <= 1'b1;
          r_busy      <= 1'b0;
          r_fsm       <= S_IDLE;
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign step_done = r_step_done;
  assign spike_vec = r_spike_vec;
  assign state_mon = r_state_mon;

endmodule

// File: tb/tb_lif_step_scheduler.sv
// Self-checking bench for lif_step_scheduler: two instances (LEAK_SHIFT 2 and 7) checked
// every cycle against a timestep-level model, plus directed literal expectations.
module tb_lif_step_scheduler;

  localparam int N   = 4;
  localparam int SYN = 8;
  localparam int REF = 2;
`ifdef LIF_REFRACTORY_EN
  localparam bit REFRAC_EN = 1'b1;
`else
  localparam bit REFRAC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       step_start = 1'b0;
  logic [3:0] ext_input = '0;
  logic [7:0] threshold = '0;
  logic [1:0] mon_sel = '0;

  logic       o_busy [2];
  logic       o_done [2];
  logic [3:0] o_spk  [2];
  logic [7:0] o_mon  [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lif_step_scheduler #(.NUM_NEURONS(N), .STATE_W(8), .LEAK_SHIFT(2), .SYN_WEIGHT(SYN),
                       .REFRAC_STEPS(REF)) u_dut0 (
    .clk(clk), .reset(reset), .step_start(step_start), .ext_input(ext_input),
    .threshold(threshold), .mon_sel(mon_sel), .busy(o_busy[0]), .step_done(o_done[0]),
    .spike_vec(o_spk[0]), .state_mon(o_mon[0]));

  lif_step_scheduler #(.NUM_NEURONS(N), .STATE_W(8), .LEAK_SHIFT(7), .SYN_WEIGHT(SYN),
                       .REFRAC_STEPS(REF)) u_dut1 (
    .clk(clk), .reset(reset), .step_start(step_start), .ext_input(ext_input),
    .threshold(threshold), .mon_sel(mon_sel), .busy(o_busy[1]), .step_done(o_done[1]),
    .spike_vec(o_spk[1]), .state_mon(o_mon[1]));

  // Timestep-level model: a whole timestep is computed at acceptance, then neuron k's new
  // state becomes visible k+1 edges later and the spike vector commits one edge after the scan.
  int m_state [2][N];
  int m_ref   [2][N];
  int p_state [2][N];
  int p_ref   [2][N];
  int m_spk   [2];
  int p_spk   [2];
  int m_cnt   [2];
  int e_busy  [2];
  int e_done  [2];
  int e_mon   [2];

  function automatic int leak_of(int c);
    return (c == 0) ? 2 : 7;
  endfunction

  task automatic compute_step(int c);
    int s, sum;
    p_spk[c] = 0;
    for (int i = 0; i < N; i++) begin
      s = m_state[c][i];
      if (REFRAC_EN && m_ref[c][i] > 0) begin
        p_state[c][i] = 0;
        p_ref[c][i]   = m_ref[c][i] - 1;
      end else begin
        sum = s - (s >> leak_of(c)) + int'(ext_input);
        if (i > 0 && ((m_spk[c] >> (i - 1)) & 1) == 1) sum += SYN;
        if (sum > 255) sum = 255;
        if (sum >= int'(threshold)) begin
          p_state[c][i] = 0;
          p_ref[c][i]   = REF;
          p_spk[c]      = p_spk[c] | (1 << i);
        end else begin
          p_state[c][i] = sum;
          p_ref[c][i]   = 0;
        end
      end
    end
  endtask

  task automatic model_edge();
    int mon_next;
    for (int c = 0; c < 2; c++) begin
      mon_next = m_state[c][mon_sel];
      if (reset) begin
        for (int i = 0; i < N; i++) begin
          m_state[c][i] = 0;
          m_ref[c][i]   = 0;
        end
        m_spk[c] = 0; m_cnt[c] = 0; e_done[c] = 0; e_mon[c] = 0;
      end else begin
        e_done[c] = 0;
        if (m_cnt[c] == 0) begin
          if (step_start) begin
            compute_step(c);
            m_cnt[c] = 1;
          end
        end else if (m_cnt[c] <= N) begin
          m_state[c][m_cnt[c]-1] = p_state[c][m_cnt[c]-1];
          m_ref[c][m_cnt[c]-1]   = p_ref[c][m_cnt[c]-1];
          m_cnt[c]++;
        end else begin
          m_spk[c]  = p_spk[c];
          e_done[c] = 1;
          m_cnt[c]  = 0;
        end
        e_mon[c] = mon_next;
      end
      e_busy[c] = (m_cnt[c] != 0) ? 1 : 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock: advance the model on the edge, compare every output at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      check($sformatf("busy[%0d]", c),      {31'd0, o_busy[c]}, e_busy[c]);
      check($sformatf("step_done[%0d]", c), {31'd0, o_done[c]}, e_done[c]);
      check($sformatf("spike_vec[%0d]", c), {28'd0, o_spk[c]},  m_spk[c]);
      check($sformatf("state_mon[%0d]", c), {24'd0, o_mon[c]},  e_mon[c]);
    end
  endtask

  task automatic run_step(input int thr, input int ext, output int cycles);
    threshold  = 8'(thr);
    ext_input  = 4'(ext);
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    cycles = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (o_done[0] === 1'b1) begin
        cycles = k;
        break;
      end
    end
    if (cycles == 0) check("step_done_timeout", 0, 1);
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, prev, last_pre, spiked, n_done, last_done;
    int exp_mon [9] = '{5, 9, 12, 14, 16, 17, 18, 19, 0};

    // Reset with step_start held high: ignored, all outputs zero.
    step_start = 1'b1; ext_input = 4'd5; threshold = 8'd20; mon_sel = 2'd0;
    do_reset(2);
    check("reset_busy", {31'd0, o_busy[0]}, 0);
    check("reset_spk",  {28'd0, o_spk[0]},  0);
    check("reset_mon",  {24'd0, o_mon[0]},  0);
    step_start = 1'b0;
    tick();
    check("after_reset_idle", {31'd0, o_busy[0]}, 0);

    // Nine steps at threshold 20, ext 5: neuron 0 trajectory, all spike at step 9.
    for (int s = 0; s < 9; s++) begin
      run_step(20, 5, cyc);
      check($sformatf("latency_step%0d", s + 1), cyc, 5);
      check($sformatf("mon_step%0d", s + 1), {24'd0, o_mon[0]}, exp_mon[s]);
    end
    check("spk_step9", {28'd0, o_spk[0]}, 4'b1111);

    // Step 10: neuron 0 restarts at ext, downstream neurons also get the synaptic weight.
    run_step(20, 5, cyc);
    check("spk_step10", {28'd0, o_spk[0]}, 0);
    check("mon_step10_n0", {24'd0, o_mon[0]}, REFRAC_EN ? 0 : 5);
    for (int i = 1; i < N; i++) begin
      mon_sel = 2'(i);
      tick();
      check($sformatf("mon_step10_n%0d", i), {24'd0, o_mon[0]}, REFRAC_EN ? 0 : 13);
    end
    mon_sel = 2'd0;

    // step_start held continuously: one step every 6 cycles.
    step_start = 1'b1;
    n_done = 0; last_done = -1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (o_done[0] === 1'b1) begin
        if (last_done >= 0) check("back_to_back_period", k - last_done, 6);
        last_done = k;
        n_done++;
      end
    end
    check("back_to_back_count", n_done, 6);
    step_start = 1'b0;
    repeat (8) tick();

    // Saturation on the LEAK_SHIFT=7 instance: rises monotonically, clips at 255 and fires.
    do_reset(1);
    prev = 0; last_pre = -1; spiked = 0;
    for (int s = 0; s < 30; s++) begin
      run_step(255, 15, cyc);
      if (o_spk[1][0] === 1'b1) begin
        spiked = 1;
        check("sat_state_after_spike", {24'd0, o_mon[1]}, 0);
        break;
      end
      check("sat_monotone", (int'(o_mon[1]) >= prev) ? 1 : 0, 1);
      prev = int'(o_mon[1]);
      last_pre = prev;
    end
    check("sat_spiked", spiked, 1);
    check("sat_last_before_spike", last_pre, 247);

    // Reset in the middle of a scan: no step_done, everything cleared, next step is step 1.
    step_start = 1'b1; threshold = 8'd20; ext_input = 4'd5;
    tick();
    step_start = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_done = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (o_done[0] === 1'b1 || o_done[1] === 1'b1) n_done++;
    end
    check("abort_no_done", n_done, 0);
    check("abort_spk", {28'd0, o_spk[0]}, 0);
    run_step(20, 5, cyc);
    check("abort_next_step_mon", {24'd0, o_mon[0]}, 5);

    // threshold 0: every neuron fires and stays at 0.
    do_reset(1);
    run_step(0, 9, cyc);
    check("thr0_spk", {28'd0, o_spk[0]}, 4'b1111);
    check("thr0_mon", {24'd0, o_mon[0]}, 0);

    // Refractory pattern at threshold 5, ext 5.
    do_reset(1);
    for (int s = 1; s <= 8; s++) begin
      run_step(5, 5, cyc);
      check($sformatf("refrac_step%0d", s), {31'd0, o_spk[0][0]},
            (!REFRAC_EN || (s % 3) == 1) ? 1 : 0);
    end

    // Randomised traffic, inputs changing freely while busy.
    for (int k = 0; k < 3000; k++) begin
      step_start = ($urandom_range(0, 9) < 7);
      ext_input  = 4'($urandom);
      case ($urandom_range(0, 9))
        0:       threshold = 8'd0;
        1:       threshold = 8'd255;
        default: threshold = 8'($urandom_range(1, 60));
      endcase
      mon_sel = 2'($urandom);
      reset   = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0; step_start = 1'b0;
    repeat (8) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
